imem_loader: RTL and testbench

//  Upstream feeder of the fetch stage. It takes the UART-received byte stream from the debug unit,

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_byte_to_word.sv | 59 +++++
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and loader state type for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned ADDRWIDTH  = 10;
    localparam int unsigned N_ELEMENTS = 1024;
    localparam int unsigned LD_NB_INST = 32;
    localparam int unsigned LD_NB_BYTE = 8;

    localparam logic [31:0] LD_HALT_WORD = 32'hFC00_0000;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_e;

    // Loader owns the imem write port only while receiving or writing.
    function automatic logic ld_active(input ld_state_e s);
        return (s == LD_RECV) || (s == LD_WRITE);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, imem write port and load status out.
interface imem_loader_if #(
    parameter int unsigned NB_INST = 32,
    parameter int unsigned NB_BYTE = 8,
    parameter int unsigned NB_ADDR = 10
);
    logic               i_start;
    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               o_debug_unit;
    logic               o_mem_wen;
    logic [NB_ADDR-1:0] o_wr_addr;
    logic [NB_INST-1:0] o_mem_data;
    logic               o_busy;
    logic               o_done;
    logic               o_overflow;
    logic [NB_ADDR-1:0] o_word_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_debug_unit, o_mem_wen, o_wr_addr, o_mem_data,
               o_busy, o_done, o_overflow, o_word_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_debug_unit, o_mem_wen, o_wr_addr, o_mem_data,
               o_busy, o_done, o_overflow, o_word_count
    );
endinterface

// File: rtl/imem_loader_byte_to_word.sv
// Big-endian byte packer: first byte of a group ends up in the MSBs.
module imem_loader_byte_to_word #(
    parameter int unsigned NB_INST = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_en,
    input  logic [NB_BYTE-1:0] i_data,
    input  logic               i_valid,
    output logic [NB_INST-1:0] o_word,
    output logic               o_word_valid,
    output logic               o_last_c
);

    localparam int unsigned N_BYTES = NB_INST / NB_BYTE;
    localparam int unsigned NB_IDX  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BYTES - 1);

    logic [NB_IDX-1:0]  r_idx;
    logic [NB_INST-1:0] r_shift;
    logic [NB_INST-1:0] r_word;
    logic               r_word_valid;
    logic               w_accept;
    logic [NB_INST-1:0] w_shift_next;

    assign w_accept     = i_en & i_valid;
    assign w_shift_next = (r_shift << NB_BYTE) | NB_INST'(i_data);
    assign o_last_c     = w_accept & (r_idx == LAST_IDX);
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

    // Clear wins over an accepted byte so leftovers are dropped on load end.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_idx        <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_idx   <= '0;
                r_shift <= '0;
            end else if (w_accept) begin
                r_shift <= w_shift_next;
                if (r_idx == LAST_IDX) begin
                    r_idx        <= '0;
                    r_word       <= w_shift_next;
                    r_word_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + NB_IDX'(1);
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Packs the debug-UART byte stream into instructions and writes them to imem.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned        NB_INST   = LD_NB_INST,
    parameter int unsigned        NB_BYTE   = LD_NB_BYTE,
    parameter int unsigned        NB_ADDR   = ADDRWIDTH,
    parameter int unsigned        MEM_WORDS = N_ELEMENTS,
    parameter int unsigned        ADDR_STEP = 1,
    parameter logic [NB_INST-1:0] HALT_WORD = NB_INST'(LD_HALT_WORD)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    imem_loader_if.slave  ld_bus
);

    ld_state_e          r_state;
    ld_state_e          w_state_next;
    logic [NB_ADDR-1:0] r_wr_addr;
    logic [NB_ADDR-1:0] w_wr_addr_next;
    logic [NB_ADDR-1:0] r_word_count;
    logic [NB_ADDR-1:0] w_word_count_next;
    logic               r_done;
    logic               w_done_next;
    logic               r_overflow;
    logic               w_overflow_next;
    logic               r_busy;
    logic               w_clear;
    logic               w_en;
    logic [NB_INST-1:0] w_word;
    logic               w_word_valid;
    logic               w_last;

    assign w_en = ld_active(r_state);

    imem_loader_byte_to_word #(
        .NB_INST (NB_INST),
        .NB_BYTE (NB_BYTE)
    ) u_pack (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_clear),
        .i_en         (w_en),
        .i_data       (ld_bus.i_rx_data),
        .i_valid      (ld_bus.i_rx_valid),
        .o_word       (w_word),
        .o_word_valid (w_word_valid),
        .o_last_c     (w_last)
    );

    // State and status registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= LD_IDLE;
            r_wr_addr    <= '0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wr_addr    <= w_wr_addr_next;
            r_word_count <= w_word_count_next;
            r_done       <= w_done_next;
            r_overflow   <= w_overflow_next;
            r_busy       <= ld_active(w_state_next);
        end
    end

    // Next-state logic; HALT takes precedence over the memory-full check.
    always_comb begin
        w_state_next      = r_state;
        w_wr_addr_next    = r_wr_addr;
        w_word_count_next = r_word_count;
        w_done_next       = r_done;
        w_overflow_next   = r_overflow;
        w_clear           = 1'b0;
        case (r_state)
            LD_IDLE, LD_DONE: begin
                if (ld_bus.i_start) begin
                    w_state_next      = LD_RECV;
                    w_wr_addr_next    = '0;
                    w_word_count_next = '0;
                    w_done_next       = 1'b0;
                    w_overflow_next   = 1'b0;
                    w_clear           = 1'b1;
                end
            end
            LD_RECV: begin
                if (w_last) begin
                    w_state_next = LD_WRITE;
                end
            end
            LD_WRITE: begin
                w_word_count_next = r_word_count + NB_ADDR'(1);
                if (w_word == HALT_WORD) begin
                    w_state_next = LD_DONE;
                    w_done_next  = 1'b1;
                    w_clear      = 1'b1;
                end else if (32'(r_word_count) + 32'd1 == 32'(MEM_WORDS)) begin
                    w_state_next    = LD_DONE;
                    w_done_next     = 1'b1;
                    w_overflow_next = 1'b1;
                    w_clear         = 1'b1;
                end else begin
                    w_wr_addr_next = r_wr_addr + NB_ADDR'(ADDR_STEP);
                    w_state_next   = LD_RECV;
                end
            end
            default: begin
                w_state_next = LD_IDLE;
            end
        endcase
    end

    // The packer's valid pulse lands exactly in the WRITE cycle.
    assign ld_bus.o_mem_wen    = w_word_valid;
    assign ld_bus.o_mem_data   = w_word;
    assign ld_bus.o_wr_addr    = r_wr_addr;
    assign ld_bus.o_word_count = r_word_count;
    assign ld_bus.o_busy       = r_busy;
    assign ld_bus.o_debug_unit = r_busy;
    assign ld_bus.o_done       = r_done;
    assign ld_bus.o_overflow   = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads vs. a word-level model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int unsigned MEM = 4;
    localparam int unsigned NA  = 4;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    typedef logic [7:0] byte_q_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.NB_INST(32), .NB_BYTE(8), .NB_ADDR(NA)) ld_bus ();

    imem_loader #(
        .NB_INST   (32),
        .NB_BYTE   (8),
        .NB_ADDR   (NA),
        .MEM_WORDS (MEM),
        .ADDR_STEP (1)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .ld_bus  (ld_bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [NA-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    logic [NA-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic          exp_done;
    logic          exp_ovf;
    int unsigned   exp_count;

    // Write log captured away from the active edge.
    always @(negedge clk) begin
        if (rst_n && ld_bus.o_mem_wen) begin
            log_addr.push_back(ld_bus.o_wr_addr);
            log_data.push_back(ld_bus.o_mem_data);
        end
    end

    // Reference: split the stream into 4-byte words, stop at HALT or when memory is full.
    function automatic void model_load(input byte_q_t s);
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_ovf  = 1'b0;
        for (int i = 0; (i + 1) * 4 <= s.size(); i++) begin
            w = {s[4*i], s[4*i+1], s[4*i+2], s[4*i+3]};
            exp_addr.push_back(NA'(i % (1 << NA)));
            exp_data.push_back(w);
            if (w == HALT) begin
                exp_done = 1'b1;
                break;
            end
            if (i + 1 == int'(MEM)) begin
                exp_done = 1'b1;
                exp_ovf  = 1'b1;
                break;
            end
        end
        exp_count = exp_data.size();
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        ld_bus.i_start = 1'b1;
        tick();
        ld_bus.i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        ld_bus.i_rx_data  = b;
        ld_bus.i_rx_valid = 1'b1;
        tick();
        ld_bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t s, input int max_gap);
        foreach (s[i]) send_byte(s[i], int'($urandom_range(max_gap, 0)));
    endtask

    task automatic push_word(inout byte_q_t s, input logic [31:0] w);
        s.push_back(w[31:24]);
        s.push_back(w[23:16]);
        s.push_back(w[15:8]);
        s.push_back(w[7:0]);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic test_reset();
        byte_q_t s;
        #1;
        n_checks++;
        if ({ld_bus.o_busy, ld_bus.o_debug_unit, ld_bus.o_mem_wen, ld_bus.o_done, ld_bus.o_overflow,
             ld_bus.o_wr_addr, ld_bus.o_mem_data, ld_bus.o_word_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b wen=%b done=%b data=%h cnt=%0d, expected all 0",
                     ld_bus.o_busy, ld_bus.o_mem_wen, ld_bus.o_done, ld_bus.o_mem_data, ld_bus.o_word_count);
        end
        #2 rst_n = 1'b1;
        tick();
        pulse_start();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ld_bus.o_busy, ld_bus.o_debug_unit, ld_bus.o_mem_wen, ld_bus.o_done, ld_bus.o_overflow,
             ld_bus.o_wr_addr, ld_bus.o_mem_data, ld_bus.o_word_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_recv: busy=%b dbg=%b data=%h, expected all 0",
                     ld_bus.o_busy, ld_bus.o_debug_unit, ld_bus.o_mem_data);
        end
        #2 rst_n = 1'b1;
        tick();
        log_addr.delete();
        log_data.delete();
        pulse_start();
        s = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(s, 0);
        idle(3);
        n_checks++;
        if (log_data.size() != 1) begin
            n_errors++;
            $display("FAIL reset_no_stale_count: writes=%0d, expected 1", log_data.size());
        end else begin
            n_checks++;
            if (log_data[0] !== 32'h11223344 || log_addr[0] !== '0) begin
                n_errors++;
                $display("FAIL reset_no_stale_data: addr=%0d data=%h, expected addr 0 data 11223344",
                         log_addr[0], log_data[0]);
            end
        end
    endtask

    task automatic test_single_word();
        do_reset();
        pulse_start();
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        n_checks++;
        if (ld_bus.o_mem_wen !== 1'b0) begin
            n_errors++;
            $display("FAIL partial_no_write: wen=%b, expected 0", ld_bus.o_mem_wen);
        end
        send_byte(8'h78, 0);
        n_checks++;
        if (ld_bus.o_mem_wen !== 1'b1 || ld_bus.o_wr_addr !== '0 || ld_bus.o_mem_data !== 32'h12345678) begin
            n_errors++;
            $display("FAIL single_write: wen=%b addr=%0d data=%h, expected 1 0 12345678",
                     ld_bus.o_mem_wen, ld_bus.o_wr_addr, ld_bus.o_mem_data);
        end
        tick();
        n_checks++;
        if (ld_bus.o_mem_wen !== 1'b0 || ld_bus.o_word_count !== NA'(1) || ld_bus.o_busy !== 1'b1 ||
            ld_bus.o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL single_after: wen=%b cnt=%0d busy=%b done=%b, expected 0 1 1 0",
                     ld_bus.o_mem_wen, ld_bus.o_word_count, ld_bus.o_busy, ld_bus.o_done);
        end
    endtask

    task automatic test_reset_write();
        do_reset();
        pulse_start();
        send_bytes('{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ld_bus.o_mem_wen !== 1'b0 || ld_bus.o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_in_write: wen=%b busy=%b, expected 0 0", ld_bus.o_mem_wen, ld_bus.o_busy);
        end
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_halt();
        byte_q_t s;
        do_reset();
        pulse_start();
        push_word(s, rand_word());
        push_word(s, rand_word());
        push_word(s, HALT);
        model_load(s);
        send_bytes(s, 2);
        idle(3);
        n_checks++;
        if (log_data.size() != 3) begin
            n_errors++;
            $display("FAIL halt_count: writes=%0d, expected 3", log_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (log_addr[i] !== NA'(i) || log_data[i] !== exp_data[i]) begin
                    n_errors++;
                    $display("FAIL halt_write%0d: addr=%0d data=%h, expected %0d %h",
                             i, log_addr[i], log_data[i], i, exp_data[i]);
                end
            end
        end
        n_checks++;
        if (ld_bus.o_done !== 1'b1 || ld_bus.o_overflow !== 1'b0 || ld_bus.o_busy !== 1'b0 ||
            ld_bus.o_debug_unit !== 1'b0 || ld_bus.o_word_count !== NA'(3)) begin
            n_errors++;
            $display("FAIL halt_status: done=%b ovf=%b busy=%b dbg=%b cnt=%0d, expected 1 0 0 0 3",
                     ld_bus.o_done, ld_bus.o_overflow, ld_bus.o_busy, ld_bus.o_debug_unit, ld_bus.o_word_count);
        end
    endtask

    task automatic test_overflow();
        byte_q_t s;
        do_reset();
        pulse_start();
        for (int i = 0; i < 5; i++) push_word(s, rand_word());
        send_bytes(s, 1);
        idle(3);
        n_checks++;
        if (log_data.size() != MEM) begin
            n_errors++;
            $display("FAIL ovf_count: writes=%0d, expected %0d", log_data.size(), MEM);
        end else begin
            for (int i = 0; i < int'(MEM); i++) begin
                n_checks++;
                if (log_addr[i] !== NA'(i) || log_data[i] !== {s[4*i], s[4*i+1], s[4*i+2], s[4*i+3]}) begin
                    n_errors++;
                    $display("FAIL ovf_write%0d: addr=%0d data=%h, expected %0d %h", i, log_addr[i],
                             log_data[i], i, {s[4*i], s[4*i+1], s[4*i+2], s[4*i+3]});
                end
            end
        end
        n_checks++;
        if (ld_bus.o_done !== 1'b1 || ld_bus.o_overflow !== 1'b1 || ld_bus.o_busy !== 1'b0 ||
            ld_bus.o_word_count !== NA'(MEM)) begin
            n_errors++;
            $display("FAIL ovf_status: done=%b ovf=%b busy=%b cnt=%0d, expected 1 1 0 %0d",
                     ld_bus.o_done, ld_bus.o_overflow, ld_bus.o_busy, ld_bus.o_word_count, MEM);
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t s;
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) push_word(s, rand_word());
        push_word(s, HALT);
        model_load(s);
        foreach (s[i]) begin
            ld_bus.i_rx_data  = s[i];
            ld_bus.i_rx_valid = 1'b1;
            ld_bus.i_start    = (i == 5) || (i == 8);
            tick();
        end
        ld_bus.i_rx_valid = 1'b0;
        ld_bus.i_start    = 1'b0;
        idle(3);
        n_checks++;
        if (log_data.size() != 4) begin
            n_errors++;
            $display("FAIL b2b_count: writes=%0d, expected 4", log_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (log_addr[i] !== NA'(i) || log_data[i] !== exp_data[i]) begin
                    n_errors++;
                    $display("FAIL b2b_write%0d: addr=%0d data=%h, expected %0d %h",
                             i, log_addr[i], log_data[i], i, exp_data[i]);
                end
            end
        end
        n_checks++;
        if (ld_bus.o_done !== 1'b1 || ld_bus.o_overflow !== 1'b0 || ld_bus.o_word_count !== NA'(4)) begin
            n_errors++;
            $display("FAIL b2b_status: done=%b ovf=%b cnt=%0d, expected 1 0 4",
                     ld_bus.o_done, ld_bus.o_overflow, ld_bus.o_word_count);
        end
    endtask

    task automatic test_reload();
        byte_q_t     s;
        logic [31:0] w;
        log_addr.delete();
        log_data.delete();
        pulse_start();
        n_checks++;
        if (ld_bus.o_done !== 1'b0 || ld_bus.o_busy !== 1'b1 || ld_bus.o_wr_addr !== '0 ||
            ld_bus.o_word_count !== '0) begin
            n_errors++;
            $display("FAIL reload_clear: done=%b busy=%b addr=%0d cnt=%0d, expected 0 1 0 0",
                     ld_bus.o_done, ld_bus.o_busy, ld_bus.o_wr_addr, ld_bus.o_word_count);
        end
        w = rand_word();
        push_word(s, w);
        push_word(s, HALT);
        send_bytes(s, 2);
        idle(3);
        n_checks++;
        if (log_data.size() != 2 || log_addr[0] !== NA'(0) || log_data[0] !== w ||
            log_addr[1] !== NA'(1) || log_data[1] !== HALT) begin
            n_errors++;
            $display("FAIL reload_writes: n=%0d first addr=%0d data=%h, expected 2 writes at 0,1 first %h",
                     log_data.size(), log_addr[0], log_data[0], w);
        end
        n_checks++;
        if (ld_bus.o_done !== 1'b1 || ld_bus.o_word_count !== NA'(2)) begin
            n_errors++;
            $display("FAIL reload_done: done=%b cnt=%0d, expected 1 2", ld_bus.o_done, ld_bus.o_word_count);
        end
    endtask

    task automatic test_random();
        byte_q_t s;
        logic    prev_done;
        int      nw;
        prev_done = 1'b0;
        for (int it = 0; it < 40; it++) begin
            s.delete();
            if (prev_done && ($urandom_range(1, 0) == 1)) begin
                log_addr.delete();
                log_data.delete();
            end else begin
                do_reset();
            end
            pulse_start();
            nw = int'($urandom_range(6, 0));
            for (int k = 0; k < nw; k++) push_word(s, ($urandom_range(3, 0) == 0) ? HALT : rand_word());
            repeat ($urandom_range(3, 0)) s.push_back(8'($urandom()));
            model_load(s);
            send_bytes(s, 2);
            idle(3);
            n_checks++;
            if (log_data.size() != exp_data.size()) begin
                n_errors++;
                $display("FAIL rand%0d_count: writes=%0d, expected %0d", it, log_data.size(), exp_data.size());
            end else begin
                foreach (exp_data[i]) begin
                    n_checks++;
                    if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) begin
                        n_errors++;
                        $display("FAIL rand%0d_write%0d: addr=%0d data=%h, expected %0d %h",
                                 it, i, log_addr[i], log_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            n_checks++;
            if (ld_bus.o_done !== exp_done || ld_bus.o_overflow !== exp_ovf ||
                ld_bus.o_busy !== !exp_done || ld_bus.o_word_count !== NA'(exp_count)) begin
                n_errors++;
                $display("FAIL rand%0d_status: done=%b ovf=%b busy=%b cnt=%0d, expected %b %b %b %0d",
                         it, ld_bus.o_done, ld_bus.o_overflow, ld_bus.o_busy, ld_bus.o_word_count,
                         exp_done, exp_ovf, !exp_done, exp_count);
            end
            prev_done = exp_done;
        end
    endtask

    initial begin
        ld_bus.i_start    = 1'b0;
        ld_bus.i_rx_data  = '0;
        ld_bus.i_rx_valid = 1'b0;
        test_reset();
        test_single_word();
        test_reset_write();
        test_halt();
        test_overflow();
        test_back_to_back();
        test_reload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
